// File: rtl/mfp_ram_stream_reader.sv
`default_nettype none
// =============================================================================
// Module      : mfp_ram_stream_reader
// Description : Scans an address window of a 1R1W RAM (one-cycle read latency)
//               and emits the words as a valid/ready stream with a last marker.
// Revision    : 1.0 - initial release
// =============================================================================
module mfp_ram_stream_reader #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH:0]   length_i,
    output logic [ADDR_WIDTH-1:0] read_addr_o,
    input  logic [DATA_WIDTH-1:0] read_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_last_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [ADDR_WIDTH:0] c_LEN_ZERO = '0;
    localparam logic [ADDR_WIDTH:0] c_LEN_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   issue_left_q, issue_left_d;
    logic [ADDR_WIDTH:0]   beat_left_q, beat_left_d;
    logic                  inflight_q, inflight_d;
    logic                  inflight_last_q, inflight_last_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [DATA_WIDTH-1:0] fifo_data_q [0:1];
    logic                  fifo_last_q [0:1];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q, count_d;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_issue;
    logic [2:0]            w_occupancy;

    assign w_push      = inflight_q;
    assign w_pop       = (count_q != 2'd0) && out_ready_i;
    // Slots already spoken for: buffered words plus the read still in the RAM pipe.
    assign w_occupancy = {1'b0, count_q} + {2'b00, inflight_q};
    assign w_issue     = (state_q == c_RUN) && (issue_left_q != c_LEN_ZERO)
                         && (w_occupancy < (3'd2 + {2'b00, w_pop}));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE: begin
                if (start_i) begin
                    state_d = (length_i == c_LEN_ZERO) ? c_DONE : c_RUN;
                end
            end
            c_RUN: begin
                if (w_pop && (beat_left_q == c_LEN_ONE)) begin
                    state_d = c_DONE;
                end
            end
            c_DONE:  state_d = c_IDLE;
            default: state_d = c_IDLE;
        endcase
    end

    // Output logic, registered so busy/done carry no combinational path
    always_comb begin
        busy_d = (state_d != c_IDLE);
        done_d = (state_d == c_DONE);
    end

    // Datapath next-state
    always_comb begin
        addr_d          = addr_q;
        issue_left_d    = issue_left_q;
        beat_left_d     = beat_left_q;
        inflight_d      = w_issue;
        inflight_last_d = w_issue && (issue_left_q == c_LEN_ONE);
        wr_ptr_d        = w_push ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d        = w_pop  ? ~rd_ptr_q : rd_ptr_q;
        count_d         = count_q;

        if ((state_q == c_IDLE) && start_i) begin
            addr_d       = base_addr_i;
            issue_left_d = length_i;
            beat_left_d  = length_i;
        end
        if (w_issue) begin
            addr_d       = addr_q + 1'b1;
            issue_left_d = issue_left_q - c_LEN_ONE;
        end
        if (w_pop) begin
            beat_left_d = beat_left_q - c_LEN_ONE;
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q          <= '0;
            issue_left_q    <= '0;
            beat_left_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
            count_q         <= 2'd0;
            fifo_data_q[0]  <= '0;
            fifo_data_q[1]  <= '0;
            fifo_last_q[0]  <= 1'b0;
            fifo_last_q[1]  <= 1'b0;
        end else begin
            addr_q          <= addr_d;
            issue_left_q    <= issue_left_d;
            beat_left_q     <= beat_left_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            if (w_push) begin
                fifo_data_q[wr_ptr_q] <= read_data_i;
                fifo_last_q[wr_ptr_q] <= inflight_last_q;
            end
        end
    end

    assign read_addr_o = addr_q;
    assign out_valid_o = (count_q != 2'd0);
    assign out_data_o  = fifo_data_q[rd_ptr_q];
    assign out_last_o  = fifo_last_q[rd_ptr_q];
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_mfp_ram_stream_reader.sv
`default_nettype none
// =============================================================================
// Module      : tb_mfp_ram_stream_reader
// Description : Directed self-checking bench for mfp_ram_stream_reader.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_mfp_ram_stream_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic [9:0]  base_addr_i = '0;
    logic [10:0] length_i = '0;
    logic [9:0]  read_addr_o;
    logic [15:0] read_data_i;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [15:0] out_data_o;
    logic        out_last_o;
    logic        busy_o;
    logic        done_o;

    int checks   = 0;
    int failures = 0;

    logic [15:0] ram [0:1023];

    always #5 clk = ~clk;

    // Registered-read RAM, one cycle latency
    always_ff @(posedge clk) read_data_i <= ram[read_addr_o];

    mfp_ram_stream_reader #(.ADDR_WIDTH(10), .DATA_WIDTH(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .length_i    (length_i),
        .read_addr_o (read_addr_o),
        .read_data_i (read_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_last_o  (out_last_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One scan: mode 0 = ready always high, mode 1 = random ready.
    // inj != 0 pulses a stray start (different window) in that cycle.
    task automatic run_scan(input logic [9:0] base, input logic [10:0] len,
                            input int mode, input int inj);
        int          c, idx, dones, first_v, last_x, done_c, busy_c, budget;
        logic        rdy, fin, prev_stall, prev_last;
        logic [15:0] prev_data, exp_data;
        logic [9:0]  exp_addr;
        idx = 0; dones = 0; first_v = -1; last_x = -1; done_c = -1; busy_c = 0;
        fin = 1'b0; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
        budget = int'(len) * 4 + 20;

        @(negedge clk);
        start_i     = 1'b1;
        base_addr_i = base;
        length_i    = len;
        out_ready_i = (mode == 0);
        @(negedge clk);
        start_i = 1'b0;
        c = 1;
        while (!fin && c < budget) begin
            rdy = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            out_ready_i = rdy;
            if (c == inj) begin
                start_i     = 1'b1;
                base_addr_i = 10'h3AA;
                length_i    = 11'd5;
            end else begin
                start_i = 1'b0;
            end
            if (busy_o) busy_c++;
            if (prev_stall) begin
                chk("hold_valid", 32'(out_valid_o), 32'd1);
                chk("hold_data",  32'(out_data_o),  32'(prev_data));
                chk("hold_last",  32'(out_last_o),  32'(prev_last));
            end
            if (out_valid_o) begin
                if (first_v < 0) first_v = c;
                exp_addr = base + idx[9:0];
                exp_data = {6'd0, exp_addr} + 16'h0100;
                chk("beat_in_window", 32'(idx < int'(len)), 32'd1);
                chk("beat_data", 32'(out_data_o), 32'(exp_data));
                chk("beat_last", 32'(out_last_o), 32'(idx == int'(len) - 1));
                if (rdy) begin
                    idx++;
                    last_x = c;
                end
            end
            prev_stall = out_valid_o && !rdy;
            prev_data  = out_data_o;
            prev_last  = out_last_o;
            if (done_o) begin
                dones++;
                done_c = c;
            end
            if (dones > 0 && !busy_o) fin = 1'b1;
            @(negedge clk);
            c++;
        end
        start_i = 1'b0;
        chk("scan_finished", 32'(fin), 32'd1);
        chk("beat_count", idx, 32'(len));
        chk("done_pulses", dones, 32'd1);
        if (mode == 0) begin
            chk("first_valid_cycle", first_v, (len == 0) ? -1 : 3);
            chk("last_xfer_edge", last_x, (len == 0) ? -1 : int'(len) + 2);
            chk("done_cycle", done_c, (len == 0) ? 1 : int'(len) + 3);
            chk("busy_cycles", busy_c, (len == 0) ? 1 : int'(len) + 3);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 16'(i) + 16'h0100;

        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(out_valid_o), 32'd0);
        chk("rst_addr",  32'(read_addr_o), 32'd0);
        chk("rst_data",  32'(out_data_o),  32'd0);
        chk("rst_last",  32'(out_last_o),  32'd0);
        chk("rst_busy",  32'(busy_o),      32'd0);
        chk("rst_done",  32'(done_o),      32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_scan(10'h010, 11'd4, 0, 0);
        run_scan(10'h3FE, 11'd4, 0, 0);
        run_scan(10'h100, 11'd16, 1, 0);
        run_scan(10'h000, 11'd0, 0, 0);
        run_scan(10'h200, 11'd8, 0, 4);
        run_scan(10'h155, 11'd1024, 0, 0);

        // Abort with two words buffered under backpressure
        @(negedge clk);
        start_i     = 1'b1;
        base_addr_i = 10'h050;
        length_i    = 11'd16;
        out_ready_i = 1'b0;
        @(negedge clk);
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_abort_valid", 32'(out_valid_o), 32'd1);
        chk("pre_abort_data",  32'(out_data_o),  32'h0150);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_valid", 32'(out_valid_o), 32'd0);
        chk("abort_busy",  32'(busy_o),      32'd0);
        chk("abort_done",  32'(done_o),      32'd0);
        out_ready_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("abort_idle_valid", 32'(out_valid_o), 32'd0);
            chk("abort_idle_done",  32'(done_o),      32'd0);
        end
        run_scan(10'h020, 11'd3, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mfp_ram_stream_reader.md
# mfp_ram_stream_reader

Sequential read-side engine for the 1R1W dual-port RAM. The engine scans a programmed address window and delivers the words as a valid/ready stream with a last marker. It sits between the RAM read port (`read_addr` / `read_data`, one-cycle registered read latency) and a streaming consumer such as a display scanout or a UART dump path. It absorbs the RAM latency and downstream backpressure with a two-entry skid buffer, so sustained throughput is one word per cycle.

## Interface
- `ADDR_WIDTH`, 10, RAM address width; must match the RAM instance.
- `DATA_WIDTH`, 16, RAM word width.
- `clk` in 1: single clock, shared with the RAM.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle request; sampled only in IDLE.
- `base_addr` in ADDR_WIDTH: first address, sampled with `start`.
- `length` in ADDR_WIDTH+1: number of words, 0..2^ADDR_WIDTH, sampled with `start`.
- `read_addr` out ADDR_WIDTH: drives the RAM read address.
- `read_data` in DATA_WIDTH: RAM read data, valid one cycle after `read_addr`.
- `out_valid` out 1: stream word valid.
- `out_ready` in 1: consumer accepts; a beat transfers when `out_valid && out_ready`.
- `out_data` out DATA_WIDTH: stream word.
- `out_last` out 1: marks the final word of the window.
- `busy` out 1: high from accepted `start` through the `done` cycle.
- `done` out 1: one-cycle pulse after the last beat transfers.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN when `start` is high and `length` != 0. Capture `addr_q = base_addr`, `issue_left = length`, `beat_left = length`.
  - IDLE → DONE when `start` is high and `length` == 0. No beats are produced.
  - RUN → DONE on the transfer of the beat where `beat_left == 1`.
  - DONE → IDLE unconditionally. `done` is high for exactly this one cycle.
- `start` in RUN or DONE is ignored and has no side effects.
- `read_addr` is always `addr_q`. The RAM has no read enable, so an issue is purely internal bookkeeping.
- Issue condition, evaluated each RUN cycle: `issue_left != 0` and `fifo_count + inflight - pop < 2`.
  - `pop` is the output handshake in that cycle.
  - `inflight` is 1 if an issue occurred in the previous cycle.
- On each issue: `addr_q` increments modulo 2^ADDR_WIDTH (wraps from all-ones to 0), and `issue_left` decrements.
- On the cycle after an issue, `read_data` is written into the 2-entry FIFO, tagged with last = (that issue was the final one).
- The FIFO never overflows; this is guaranteed by the issue condition. Push and pop in the same cycle are legal and leave the count unchanged.
- `out_valid` = FIFO not empty. `out_data` and `out_last` come from the FIFO head.
- While `out_valid` is high and `out_ready` is low, `out_data` and `out_last` are held stable.
- `beat_left` decrements on each transfer.
- `out_ready` may be asserted while `out_valid` is low; this has no effect.
- `length` = 2^ADDR_WIDTH reads every RAM location exactly once, starting at `base_addr` and wrapping.
- RAM writes to the window during a scan are not hazard-protected. Each word read reflects RAM contents at its issue cycle.

## Timing
- All outputs are registered except `read_addr` (from `addr_q`) and `out_valid`/`out_data`/`out_last` (from FIFO registers). No combinational path runs from `out_ready` to any output.
- Reset values: state IDLE, `read_addr` 0, `out_valid` 0, `out_data` 0, `out_last` 0, `busy` 0, `done` 0, FIFO empty, inflight 0.
- Assertion of `rst` mid-scan aborts the scan on the next edge. In-flight and buffered words are discarded, and `done` is not pulsed.
- With `start` accepted at edge E0:
  - `read_addr = base_addr` during cycle E0..E1.
  - The word is captured into the FIFO at E2.
  - `out_valid` is first high after E2.
  - Latency from `start` edge to first valid is 2 cycles.
- With `out_ready` held high, one beat transfers per cycle with no bubbles. Last beat transfers at edge E(length+2), `done` is high in the following cycle, and the FSM is back in IDLE one cycle later.
- `busy` rises the cycle after the accepted `start` and falls together with the end of `done`.
- A new `start` is accepted in the first IDLE cycle after DONE. Minimum gap between scans is 1 cycle.

## Test plan
- RAM preloaded with addr+0x100, `base_addr`=0x010, `length`=4, `out_ready`=1 → beats 0x110, 0x111, 0x112, 0x113 on consecutive cycles, first valid 2 cycles after `start`, `out_last` only on 0x113, one `done` pulse.
- Wrap: `base_addr`=0x3FE, `length`=4 → addresses 0x3FE, 0x3FF, 0x000, 0x001 in order; exactly 4 beats.
- Backpressure: `length`=16, `out_ready` random 50% → all 16 words in order, no loss or duplication, `out_data` stable whenever valid and not ready, FIFO never exceeds 2.
- `length`=0 → no `out_valid`, `busy` high 1 cycle, `done` pulses once; `start` during RUN of a 8-word scan → ignored, exactly 8 beats.
- Full window: `length`=1024 with `out_ready`=1 → 1024 beats, last beat at edge E1026, `done` next cycle.
- `rst` asserted mid-scan with 2 words buffered → next cycle `out_valid`=0, `busy`=0, no `done`; a subsequent `start` runs cleanly from its new `base_addr`.
